wave_rom_nco: RTL and testbench

WAVE_ROM_NCO -- requirements
Module: wave_rom_nco

---
 rtl/wave_rom_pkg.sv | 40 ++++
 rtl/quarter_sin_rom.sv | 43 ++++
 rtl/wave_rom_nco.sv | 130 +++++++++++++
 tb/tb_wave_rom_nco.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wave_rom_pkg.sv
// Shared definitions for the wave ROM NCO: waveform mode encodings,
// the default quarter-sine table, and the elaboration-time table generator.
// Pure declarations, no logic.
package wave_rom_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'b00,
    MODE_TRI    = 2'b01,
    MODE_SQUARE = 2'b10,
    MODE_SAW    = 2'b11
  } mode_t;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_AMP_W  = 6;

  // Quarter-wave sine, 32 entries of 6-bit unsigned amplitude (peak 31).
  localparam int DEF_TABLE [32] = '{
    0, 2, 3, 5, 6, 8, 9, 11, 12, 14, 15, 16, 18, 19, 20, 21,
    22, 24, 25, 25, 26, 27, 28, 28, 29, 30, 30, 30, 31, 31, 31, 31
  };

  // round((2^(amp_w-1)-1) * sin(pi/2 * i / (2^addr_w-1))), Taylor series so
  // it evaluates as a constant function without relying on $sin support.
  function automatic int sin_entry(int addr_w, int amp_w, int i);
    real x;
    real term;
    real sum;
    real amp;
    x    = 3.14159265358979 / 2.0 * real'(i) / real'((1 << addr_w) - 1);
    term = x;
    sum  = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = real'((1 << (amp_w - 1)) - 1);
    return $rtoi(amp * sum + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sin_rom.sv
// Quarter-wave sine ROM with registered, enabled read.
// Latency: 1 cycle from addr to data; data holds while en=0.
// No backpressure; peak is the constant last entry (used for square wave).
module quarter_sin_rom
  import wave_rom_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int AMP_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [AMP_W-1:0]  data,
  output logic [AMP_W-1:0]  peak
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [AMP_W-1:0] table_mem [DEPTH];

  // Default geometry uses the fixed table; any other geometry is generated.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    if (ADDR_W == DEF_ADDR_W && AMP_W == DEF_AMP_W) begin : g_def
      assign table_mem[i] = AMP_W'(DEF_TABLE[i]);
    end else begin : g_gen
      localparam int VAL = sin_entry(ADDR_W, AMP_W, i);
      assign table_mem[i] = AMP_W'(VAL);
    end
  end

  assign peak = table_mem[DEPTH-1];

  // Registered read, only advancing when a sample is being taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data <= table_mem[addr];
    end
  end

endmodule

// File: rtl/wave_rom_nco.sv
// Numerically controlled oscillator: sine/triangle/square/saw from a quarter-wave ROM.
// Latency: 2 cycles from the en cycle's phase to data_out/valid.
// No backpressure; en gates phase advance, idle cycles emit data_out=0, valid=0.
module wave_rom_nco
  import wave_rom_pkg::*;
#(
  parameter  int ACC_W  = 16,
  parameter  int ADDR_W = 5,
  parameter  int AMP_W  = 6,
  localparam int DATA_W = AMP_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [ACC_W-1:0]         freq_word,
  input  logic [1:0]               mode,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     valid
);

  localparam int PH_W = ADDR_W + 2;

  if (ACC_W < ADDR_W + 2 || ACC_W < DATA_W) begin : g_bad_params
    $error("wave_rom_nco: ACC_W must be >= ADDR_W+2 and >= AMP_W+1");
  end

  logic [ACC_W-1:0]         acc;
  logic [PH_W-1:0]          phase;
  logic [1:0]               quad;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W-1:0]        addr;
  logic                     neg;
  logic signed [DATA_W-1:0] saw;

  // Stage A state (ROM output lives inside the ROM instance).
  logic                     v_a;
  logic                     neg_a;
  mode_t                    mode_a;
  logic [ADDR_W-1:0]        addr_a;
  logic signed [DATA_W-1:0] saw_a;
  logic [AMP_W-1:0]         rom_a;
  logic [AMP_W-1:0]         peak;

  logic [DATA_W-1:0]        mag;
  logic signed [DATA_W-1:0] sample;

  // Quadrant fold: odd quadrants mirror the index (N-1-idx == ~idx),
  // the upper half of the period is negated.
  assign phase = acc[ACC_W-1 -: PH_W];
  assign quad  = phase[PH_W-1 -: 2];
  assign idx   = phase[ADDR_W-1:0];
  assign addr  = quad[0] ? ~idx : idx;
  assign neg   = quad[1];
  assign saw   = $signed(acc[ACC_W-1 -: DATA_W]) >>> 1;

  // Phase accumulator: clear wins over advance, wraps modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + freq_word;
    end
  end

  quarter_sin_rom #(
    .ADDR_W (ADDR_W),
    .AMP_W  (AMP_W)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .addr (addr),
    .data (rom_a),
    .peak (peak)
  );

  // Stage A: mode and fold info travel with the sample so a mode change
  // never corrupts samples already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_a    <= 1'b0;
      neg_a  <= 1'b0;
      mode_a <= MODE_SINE;
      addr_a <= '0;
      saw_a  <= '0;
    end else begin
      v_a <= en;
      if (en) begin
        neg_a  <= neg;
        mode_a <= mode_t'(mode);
        addr_a <= addr;
        saw_a  <= saw;
      end
    end
  end

  // Waveform select and sign application for stage B.
  always_comb begin
    mag    = '0;
    sample = '0;
    case (mode_a)
      MODE_SINE:   mag = DATA_W'(rom_a);
      MODE_TRI:    mag = DATA_W'(addr_a);
      MODE_SQUARE: mag = DATA_W'(peak);
      default:     mag = '0;
    endcase
    if (mode_a == MODE_SAW) begin
      sample = saw_a;
    end else if (neg_a) begin
      sample = -$signed(mag);
    end else begin
      sample = $signed(mag);
    end
  end

  // Stage B: registered output, forced to zero on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid    <= v_a;
      data_out <= v_a ? sample : '0;
    end
  end

endmodule

// File: tb/tb_wave_rom_nco.sv
// Directed + random bench for wave_rom_nco with a two-stage expected-sample queue.
// Each cycle pushes the sample the stimulus should produce and pops the one due now.
// Accumulator is tracked by a bench model and compared every cycle.
module tb_wave_rom_nco;

  localparam int ACC_W  = 16;
  localparam int ADDR_W = 5;
  localparam int AMP_W  = 6;
  localparam int DATA_W = AMP_W + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic                     clr;
  logic [ACC_W-1:0]         freq_word;
  logic [1:0]               mode;
  logic signed [DATA_W-1:0] data_out;
  logic                     valid;

  always #5 clk = ~clk;

  wave_rom_nco #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W),
    .AMP_W  (AMP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .freq_word (freq_word),
    .mode      (mode),
    .data_out  (data_out),
    .valid     (valid)
  );

  typedef struct {
    bit vld;
    int dat;
  } samp_t;

  samp_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_acc  = '0;
  string       step_name = "init";

  int sin_tbl [32] = '{
    0, 2, 3, 5, 6, 8, 9, 11, 12, 14, 15, 16, 18, 19, 20, 21,
    22, 24, 25, 25, 26, 27, 28, 28, 29, 30, 30, 30, 31, 31, 31, 31
  };

  function automatic samp_t model_sample(logic [15:0] a, logic [1:0] md);
    samp_t s;
    int ph, q, ix, ad, mag, k;
    ph  = int'(a) >> 9;
    q   = ph / 32;
    ix  = ph % 32;
    ad  = (q == 1 || q == 3) ? 31 - ix : ix;
    mag = 0;
    case (md)
      2'd0: mag = sin_tbl[ad];
      2'd1: mag = ad;
      2'd2: mag = 31;
      default: mag = 0;
    endcase
    s.vld = 1'b1;
    if (md == 2'd3) begin
      k = ph;
      if (k >= 64) k = k - 128;
      s.dat = (k >= 0) ? k / 2 : -((-k + 1) / 2);
    end else begin
      s.dat = (q >= 2) ? -mag : mag;
    end
    return s;
  endfunction

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0d expected %0d", step_name, tag, obs, exp);
    end
  endtask

  task automatic cyc(bit r, bit e, bit c, logic [1:0] md, logic [15:0] fw);
    samp_t s;
    samp_t o;
    rst       = r;
    en        = e;
    clr       = c;
    mode      = md;
    freq_word = fw;
    if (r) begin
      exp_q.delete();
      s.vld = 1'b0;
      s.dat = 0;
      exp_q.push_back(s);
      exp_q.push_back(s);
      m_acc = '0;
    end else begin
      if (e) begin
        s = model_sample(m_acc, md);
      end else begin
        s.vld = 1'b0;
        s.dat = 0;
      end
      exp_q.push_back(s);
      if (c) m_acc = '0;
      else if (e) m_acc = m_acc + fw;
    end
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check("valid", {31'b0, valid}, {31'b0, o.vld});
    check("data_out", 32'(data_out), o.dat);
    check("acc", {16'b0, dut.acc}, {16'b0, m_acc});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; freq_word = '0; mode = 2'd0;

    step_name = "reset";
    repeat (3) cyc(1, 0, 0, 2'd0, 16'd0);

    step_name = "sine";
    repeat (132) cyc(0, 1, 0, 2'd0, 16'd512);

    step_name = "triangle";
    cyc(1, 0, 0, 2'd1, 16'd0);
    repeat (132) cyc(0, 1, 0, 2'd1, 16'd512);

    step_name = "square";
    cyc(1, 0, 0, 2'd2, 16'd0);
    repeat (132) cyc(0, 1, 0, 2'd2, 16'd512);

    step_name = "saw";
    cyc(1, 0, 0, 2'd3, 16'd0);
    repeat (132) cyc(0, 1, 0, 2'd3, 16'd512);

    step_name = "wrap";
    cyc(1, 0, 0, 2'd0, 16'd0);
    cyc(0, 1, 0, 2'd0, 16'hFE00);
    cyc(0, 1, 0, 2'd0, 16'd512);
    check("wrap_acc_literal", {16'b0, dut.acc}, 32'd0);
    repeat (6) cyc(0, 1, 0, 2'd0, 16'd512);

    step_name = "gate";
    for (int i = 0; i < 30; i++) cyc(0, (i % 3) == 0, 0, 2'd0, 16'd512);

    step_name = "hold";
    repeat (5) cyc(0, 0, 0, 2'd0, 16'd512);
    repeat (8) cyc(0, 1, 0, 2'd1, 16'd512);

    step_name = "clr";
    cyc(1, 0, 0, 2'd0, 16'd0);
    repeat (10) cyc(0, 1, 0, 2'd0, 16'd512);
    cyc(0, 1, 1, 2'd0, 16'd512);
    check("clr_acc_literal", {16'b0, dut.acc}, 32'd0);
    repeat (4) cyc(0, 1, 0, 2'd0, 16'd512);

    step_name = "rst_mid";
    repeat (40) cyc(0, 1, 0, 2'd0, 16'd512);
    cyc(1, 1, 1, 2'd0, 16'd512);
    check("rst_mid_valid_literal", {31'b0, valid}, 32'd0);
    repeat (6) cyc(0, 1, 0, 2'd0, 16'd512);

    step_name = "random";
    for (int i = 0; i < 300; i++) begin
      cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          2'($urandom_range(0, 3)), 16'($urandom));
    end
    repeat (3) cyc(0, 0, 0, 2'd0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
